spinnaker_fpgas_spi_bus_router: RTL and testbench

SPINNAKER_FPGAS_SPI_BUS_ROUTER -- requirements
Module: spinnaker_fpgas_spi_bus_router

---
 rtl/spinnaker_fpgas_spi_pkg.sv | 12 +
 rtl/spinnaker_fpgas_spi_timeout_counter.sv | 31 +++
 rtl/spinnaker_fpgas_spi_bus_router.sv | 154 +++++++++++++++
 tb/tb_spinnaker_fpgas_spi_bus_router.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spinnaker_fpgas_spi_pkg.sv
// Shared definitions for the SPI bus router: FSM state encoding and the
// default read value returned on a failed transaction.
package spinnaker_fpgas_spi_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] DEFAULT_ERR_VALUE = 32'hDEAD_BEEF;

endpackage

// File: rtl/spinnaker_fpgas_spi_timeout_counter.sv
// WAIT-state timeout counter for the SPI bus router. Counts enabled cycles
// from a clear and flags the cycle in which LIMIT enabled cycles have elapsed.
module spinnaker_fpgas_spi_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_BITS = $clog2(LIMIT + 1);

    logic [CNT_BITS-1:0] count_q;

    // Expiry is flagged during the LIMIT-th enabled cycle.
    assign expired = enable && (count_q == CNT_BITS'(LIMIT - 1));

    // Count enabled cycles; saturate once expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/spinnaker_fpgas_spi_bus_router.sv
// SPI bus router: decodes the top SEL_BITS of an SPI register address to one of
// NUM_DEVS devices, issues a one-cycle read/write strobe and returns the
// device's ack/data to the SPI side. Unmapped selects and conflicting strobes
// complete immediately with an error.
// Optional feature: define SPI_BUS_ROUTER_TIMEOUT_EN to abort WAIT with an
// error after TIMEOUT_CYCLES cycles without an ack.
module spinnaker_fpgas_spi_bus_router
    import spinnaker_fpgas_spi_pkg::*;
#(
    parameter int unsigned   SPI_ADDR_BITS  = 32,
    parameter int unsigned   VAL_BITS       = 32,
    parameter int unsigned   SEL_BITS       = 2,
    parameter int unsigned   NUM_DEVS       = 4,
    parameter int unsigned   TIMEOUT_CYCLES = 255,
    parameter logic [VAL_BITS-1:0] ERR_VALUE = VAL_BITS'(DEFAULT_ERR_VALUE)
) (
    input  logic                              CLK_IN,
    input  logic                              RESET_N_IN,
    input  logic [SPI_ADDR_BITS-1:0]          SPI_ADDR_IN,
    input  logic                              SPI_READ_IN,
    input  logic                              SPI_WRITE_IN,
    input  logic [VAL_BITS-1:0]               SPI_WRITE_VALUE_IN,
    output logic                              SPI_BUSY_OUT,
    output logic                              SPI_DONE_OUT,
    output logic                              SPI_ERR_OUT,
    output logic [VAL_BITS-1:0]               SPI_READ_VALUE_OUT,
    output logic [SPI_ADDR_BITS-SEL_BITS-1:0] DEV_ADDR_OUT,
    output logic [VAL_BITS-1:0]               DEV_WRITE_VALUE_OUT,
    output logic [NUM_DEVS-1:0]               DEV_READ_OUT,
    output logic [NUM_DEVS-1:0]               DEV_WRITE_OUT,
    input  logic [NUM_DEVS-1:0]               DEV_ACK_IN,
    input  logic [NUM_DEVS*VAL_BITS-1:0]      DEV_READ_VALUE_IN
);

    localparam int unsigned DEV_ADDR_BITS = SPI_ADDR_BITS - SEL_BITS;
    localparam int unsigned NSEL          = 2 ** SEL_BITS;

    if (NUM_DEVS < 1 || NUM_DEVS > NSEL || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("spinnaker_fpgas_spi_bus_router: illegal NUM_DEVS or TIMEOUT_CYCLES");
    end

    logic [1:0]               state_q, state_d;
    logic [SEL_BITS-1:0]      sel_q;
    logic                     write_q;
    logic [DEV_ADDR_BITS-1:0] addr_q;
    logic [VAL_BITS-1:0]      wdata_q;
    logic [VAL_BITS-1:0]      rdata_q;
    logic                     err_q;
    logic                     done_q;

    logic [SEL_BITS-1:0]      sel_in;
    logic                     req_any;
    logic                     req_bad;
    logic                     sel_ack;
    logic                     timeout_hit;
    logic [NUM_DEVS-1:0]      sel_onehot;

    // Per-select views padded to the full select space so indexing by sel_q
    // never runs past the real device count.
    logic [VAL_BITS-1:0]      dev_rd [NSEL];
    logic [NSEL-1:0]          ack_ext;

    for (genvar i = 0; i < NSEL; i++) begin : g_dev
        if (i < NUM_DEVS) begin : g_real
            assign dev_rd[i]  = DEV_READ_VALUE_IN[i*VAL_BITS +: VAL_BITS];
            assign ack_ext[i] = DEV_ACK_IN[i];
        end else begin : g_pad
            assign dev_rd[i]  = '0;
            assign ack_ext[i] = 1'b0;
        end
    end

    assign sel_in  = SPI_ADDR_IN[SPI_ADDR_BITS-1 -: SEL_BITS];
    assign req_any = SPI_READ_IN | SPI_WRITE_IN;
    // Conflicting strobes or an unmapped select finish at once with an error.
    assign req_bad = (SPI_READ_IN & SPI_WRITE_IN) | (32'(sel_in) >= NUM_DEVS);
    assign sel_ack = ack_ext[sel_q];

`ifdef SPI_BUS_ROUTER_TIMEOUT_EN
    spinnaker_fpgas_spi_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (CLK_IN),
        .rst_n   (RESET_N_IN),
        .clear   ((state_q == ST_IDLE) && (state_d == ST_REQ)),
        .enable  (state_q == ST_WAIT),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_any) state_d = req_bad ? ST_DONE : ST_REQ;
            ST_REQ:  state_d = sel_ack ? ST_DONE : ST_WAIT;
            ST_WAIT: if (sel_ack || timeout_hit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // One-hot decode of the latched select.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < int'(NUM_DEVS); i++) begin
            sel_onehot[i] = (sel_q == SEL_BITS'(i));
        end
    end

    // State, request capture and result latching.
    always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
        if (!RESET_N_IN) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // Pulse on leaving DONE so busy drops in the same cycle.
            done_q  <= (state_q == ST_DONE);
            if (state_q == ST_IDLE && req_any) begin
                sel_q   <= sel_in;
                write_q <= SPI_WRITE_IN;
                addr_q  <= SPI_ADDR_IN[DEV_ADDR_BITS-1:0];
                wdata_q <= SPI_WRITE_VALUE_IN;
                err_q   <= req_bad;
                rdata_q <= req_bad ? ERR_VALUE : '0;
            end else if ((state_q == ST_REQ || state_q == ST_WAIT) && sel_ack) begin
                err_q <= 1'b0;
                if (!write_q) rdata_q <= dev_rd[sel_q];
            end else if (state_q == ST_WAIT && timeout_hit) begin
                err_q   <= 1'b1;
                rdata_q <= ERR_VALUE;
            end
        end
    end

    assign SPI_BUSY_OUT        = (state_q != ST_IDLE);
    assign SPI_DONE_OUT        = done_q;
    assign SPI_ERR_OUT         = err_q;
    assign SPI_READ_VALUE_OUT  = rdata_q;
    assign DEV_ADDR_OUT        = addr_q;
    assign DEV_WRITE_VALUE_OUT = wdata_q;
    assign DEV_READ_OUT        = (state_q == ST_REQ && !write_q) ? sel_onehot : '0;
    assign DEV_WRITE_OUT       = (state_q == ST_REQ &&  write_q) ? sel_onehot : '0;

endmodule

// File: tb/tb_spinnaker_fpgas_spi_bus_router.sv
// Directed bench for spinnaker_fpgas_spi_bus_router. Expected completions are
// queued when a request is driven and compared when SPI_DONE_OUT fires.
module tb_spinnaker_fpgas_spi_bus_router;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    // Main instance: 4 devices, timeout 8 when the feature is built in.
    logic [31:0]  spi_addr = '0;
    logic         spi_read = 1'b0, spi_write = 1'b0;
    logic [31:0]  spi_wval = '0;
    logic         busy, done, err;
    logic [31:0]  rval;
    logic [29:0]  dev_addr;
    logic [31:0]  dev_wval;
    logic [3:0]   dev_rd, dev_wr;
    logic [3:0]   dev_ack = '0;
    logic [127:0] dev_rv = '0;

    // Second instance: 3 devices, for the unmapped-select case.
    logic [31:0]  b_addr = '0;
    logic         b_read = 1'b0;
    logic         b_busy, b_done, b_err;
    logic [31:0]  b_rval;
    logic [29:0]  b_dev_addr;
    logic [31:0]  b_dev_wval;
    logic [2:0]   b_dev_rd, b_dev_wr;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    int rd_strobes = 0, wr_strobes = 0, done_cnt = 0, b_strobes = 0;

    spinnaker_fpgas_spi_bus_router #(
        .NUM_DEVS       (4),
        .TIMEOUT_CYCLES (8)
    ) u_dut (
        .CLK_IN              (clk),
        .RESET_N_IN          (rst_n),
        .SPI_ADDR_IN         (spi_addr),
        .SPI_READ_IN         (spi_read),
        .SPI_WRITE_IN        (spi_write),
        .SPI_WRITE_VALUE_IN  (spi_wval),
        .SPI_BUSY_OUT        (busy),
        .SPI_DONE_OUT        (done),
        .SPI_ERR_OUT         (err),
        .SPI_READ_VALUE_OUT  (rval),
        .DEV_ADDR_OUT        (dev_addr),
        .DEV_WRITE_VALUE_OUT (dev_wval),
        .DEV_READ_OUT        (dev_rd),
        .DEV_WRITE_OUT       (dev_wr),
        .DEV_ACK_IN          (dev_ack),
        .DEV_READ_VALUE_IN   (dev_rv)
    );

    spinnaker_fpgas_spi_bus_router #(
        .NUM_DEVS (3)
    ) u_dut3 (
        .CLK_IN              (clk),
        .RESET_N_IN          (rst_n),
        .SPI_ADDR_IN         (b_addr),
        .SPI_READ_IN         (b_read),
        .SPI_WRITE_IN        (1'b0),
        .SPI_WRITE_VALUE_IN  (32'h0),
        .SPI_BUSY_OUT        (b_busy),
        .SPI_DONE_OUT        (b_done),
        .SPI_ERR_OUT         (b_err),
        .SPI_READ_VALUE_OUT  (b_rval),
        .DEV_ADDR_OUT        (b_dev_addr),
        .DEV_WRITE_VALUE_OUT (b_dev_wval),
        .DEV_READ_OUT        (b_dev_rd),
        .DEV_WRITE_OUT       (b_dev_wr),
        .DEV_ACK_IN          (3'b000),
        .DEV_READ_VALUE_IN   (96'h0)
    );

    always #5 clk = ~clk;

    // Event counters sampled away from the active edge.
    always @(negedge clk) begin
        if (dev_rd != 4'b0) rd_strobes++;
        if (dev_wr != 4'b0) wr_strobes++;
        if (done === 1'b1) done_cnt++;
        if (b_dev_rd != 3'b0 || b_dev_wr != 3'b0) b_strobes++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Wait (bounded) for the completion pulse, then score it against the queue.
    task automatic wait_done(input string tag, input int budget, output int cycles);
        exp_t e;
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (done === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_err"}, 64'(err), 64'(e.err));
            check({tag, "_rdata"}, 64'(rval), 64'(e.rdata));
            check({tag, "_busy_low"}, 64'(busy), 64'd0);
        end else begin
            check({tag, "_done_seen"}, 64'(done), 64'd1);
        end
    endtask

    int cyc;
    int snap_rd, snap_wr, snap_done;

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_err", 64'(err), 0);
        check("rst_rval", 64'(rval), 0);
        check("rst_strobes", 64'({dev_rd, dev_wr}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Read dev2, ack two cycles after the strobe.
        dev_rv = {32'h3333_3333, 32'h1234_5678, 32'h2222_2222, 32'h1111_1111};
        spi_addr = 32'h8000_0010; spi_read = 1'b1; spi_wval = 32'h0;
        sb.push_back('{err: 1'b0, rdata: 32'h1234_5678});
        @(negedge clk);
        spi_read = 1'b0;
        check("rd_strobe", 64'(dev_rd), 64'h4);
        check("rd_addr", 64'(dev_addr), 64'h10);
        check("rd_busy", 64'(busy), 1);
        @(negedge clk);
        check("rd_strobe_once", 64'(dev_rd), 0);
        @(negedge clk);
        dev_ack = 4'b0100;
        @(negedge clk);
        dev_ack = 4'b0000;
        wait_done("rd", 10, cyc);
        @(negedge clk);
        check("rd_done_pulse", 64'(done), 0);
        check("rd_hold", 64'(rval), 64'h1234_5678);

        // Write dev1, ack in the REQ cycle: done three cycles after the strobe.
        spi_addr = 32'h4000_0004; spi_write = 1'b1; spi_wval = 32'h0000_CAFE;
        sb.push_back('{err: 1'b0, rdata: 32'h0});
        @(negedge clk);
        spi_write = 1'b0;
        dev_ack = 4'b0010;
        check("wr_strobe", 64'(dev_wr), 64'h2);
        check("wr_value", 64'(dev_wval), 64'hCAFE);
        check("wr_addr", 64'(dev_addr), 64'h4);
        @(negedge clk);
        dev_ack = 4'b0000;
        wait_done("wr", 10, cyc);
        check("wr_latency", 64'(cyc + 2), 3);

        // Both strobes at once: error, no device strobe.
        @(negedge clk);
        snap_rd = rd_strobes; snap_wr = wr_strobes;
        spi_addr = 32'h0000_0000; spi_read = 1'b1; spi_write = 1'b1;
        sb.push_back('{err: 1'b1, rdata: 32'hDEAD_BEEF});
        @(negedge clk);
        spi_read = 1'b0; spi_write = 1'b0;
        wait_done("both", 10, cyc);
        check("both_no_strobe", 64'((rd_strobes - snap_rd) + (wr_strobes - snap_wr)), 0);

        // Unmapped select on the 3-device instance.
        b_addr = 32'hC000_0000; b_read = 1'b1;
        @(negedge clk);
        b_read = 1'b0;
        cyc = 0;
        while (b_done !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("unmap_done", 64'(b_done), 1);
        check("unmap_err", 64'(b_err), 1);
        check("unmap_rval", 64'(b_rval), 64'hDEAD_BEEF);
        check("unmap_no_strobe", 64'(b_strobes), 0);

        // Dev3 read with a second request while busy and a stray dev0 ack.
        @(negedge clk);
        snap_wr = wr_strobes;
        spi_addr = 32'hC000_0020; spi_read = 1'b1;
        sb.push_back('{err: 1'b0, rdata: 32'h3333_3333});
        @(negedge clk);
        spi_read = 1'b0;
        check("d3_strobe", 64'(dev_rd), 64'h8);
        spi_addr = 32'h0000_0000; spi_write = 1'b1; spi_wval = 32'h0000_BEEF;
        @(negedge clk);
        spi_write = 1'b0;
        dev_ack = 4'b0001;
        @(negedge clk);
        dev_ack = 4'b0000;
        check("d3_stray_ignored", 64'(busy), 1);
        @(negedge clk);
        dev_ack = 4'b1000;
        @(negedge clk);
        dev_ack = 4'b0000;
        wait_done("d3", 10, cyc);
        repeat (3) @(negedge clk);
        check("d3_second_ignored", 64'(wr_strobes - snap_wr), 0);
        check("d3_idle_after", 64'(busy), 0);
        check("d3_wval_kept", 64'(dev_wval), 64'hCAFE);

        // No ack: timeout error, or indefinite WAIT without the feature.
        spi_addr = 32'h4000_0000; spi_read = 1'b1;
`ifdef SPI_BUS_ROUTER_TIMEOUT_EN
        sb.push_back('{err: 1'b1, rdata: 32'hDEAD_BEEF});
        @(negedge clk);
        spi_read = 1'b0;
        wait_done("tmo", 30, cyc);
        check("tmo_latency", 64'(cyc + 1), 11);
        @(negedge clk);
`else
        @(negedge clk);
        spi_read = 1'b0;
        repeat (1000) @(negedge clk);
        check("nto_busy", 64'(busy), 1);
        check("nto_no_done", 64'(done), 0);
`endif

        // Asynchronous reset during WAIT, then a late ack must not complete.
        spi_addr = 32'h8000_0040; spi_read = 1'b1; spi_wval = 32'h5555_AAAA;
        @(negedge clk);
        spi_read = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 0);
        check("arst_done", 64'(done), 0);
        check("arst_err", 64'(err), 0);
        check("arst_rval", 64'(rval), 0);
        check("arst_addr", 64'(dev_addr), 0);
        check("arst_wval", 64'(dev_wval), 0);
        check("arst_strobes", 64'({dev_rd, dev_wr}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        snap_done = done_cnt; snap_rd = rd_strobes; snap_wr = wr_strobes;
        @(negedge clk);
        dev_ack = 4'b0110;
        repeat (2) @(negedge clk);
        dev_ack = 4'b0000;
        repeat (8) @(negedge clk);
        check("late_ack_no_done", 64'(done_cnt - snap_done), 0);
        check("late_no_strobe", 64'((rd_strobes - snap_rd) + (wr_strobes - snap_wr)), 0);
        check("late_idle", 64'(busy), 0);
        check("sb_empty", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
